// File: rtl/mul_issue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mul_issue_pkg                                                    |
// | Purpose : Shared types for the multiply issue stage: the M-extension       |
// |           multiply opcode and its mapping onto multiplier signed modes.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package mul_issue_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  // Bit 0: rs1 treated as signed, bit 1: rs2 treated as signed.
  // MUL only needs the low word, which is identical for any signedness, so
  // it shares the signed/signed mode with MULH.
  function automatic logic [1:0] signed_mode(input mul_op_e op);
    case (op)
      MUL, MULH: signed_mode = 2'b11;
      MULHSU:    signed_mode = 2'b01;
      default:   signed_mode = 2'b00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mul_issue                                                        |
// | Purpose : Issue/sequencing stage in front of the iterative multiplier.     |
// |           Decodes the multiply op, selects the multiplier mode, steps it   |
// |           to completion, short-cuts narrow MULs and identical repeats.     |
// | Ports   : clk, reset (async, active high)                                  |
// |           en_i/kill_i/op_i/first_operand_i/second_operand_i : request      |
// |           hold_o/result_valid_o/result_o                   : to pipeline   |
// |           mul_*_o                                          : to multiplier |
// |           mul_hold_i/mul_result_i                        : from multiplier |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mul_issue
  import mul_issue_pkg::*;
#(
  parameter bit NARROW_EN = 1'b1,
  parameter bit CACHE_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic        kill_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] first_operand_i,
  input  logic [31:0] second_operand_i,
  output logic        hold_o,
  output logic        result_valid_o,
  output logic [31:0] result_o,
  output logic [31:0] mul_first_operand_o,
  output logic [31:0] mul_second_operand_o,
  output logic [1:0]  mul_signed_mode_o,
  output logic        mul_enable_o,
  output logic        mul_low_o,
  output logic        mul_single_cycle_o,
  input  logic        mul_hold_i,
  input  logic [31:0] mul_result_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } issue_state_e;

  issue_state_e r_state;
  mul_op_e      r_op;
  logic [31:0]  r_a;
  logic [31:0]  r_b;

  logic         r_cache_valid;
  mul_op_e      r_cache_op;
  logic [31:0]  r_cache_a;
  logic [31:0]  r_cache_b;
  logic [31:0]  r_cache_data;

  issue_state_e w_next_state;
  mul_op_e      w_op;
  mul_op_e      w_cur_op;
  logic [31:0]  w_cur_a;
  logic [31:0]  w_cur_b;
  logic         w_accept;
  logic         w_hit;
  logic         w_narrow;
  logic         w_latch;
  logic         w_cache_wr;

  assign w_op = mul_op_e'(op_i);

  // In IDLE the multiplier sees the live request; once launched it only ever
  // sees the latched copy so the pipeline may change its inputs freely.
  assign w_cur_op = (r_state == IDLE) ? w_op             : r_op;
  assign w_cur_a  = (r_state == IDLE) ? first_operand_i  : r_a;
  assign w_cur_b  = (r_state == IDLE) ? second_operand_i : r_b;

  // Gating with reset keeps the narrow path from reporting a result while
  // reset is asserted.
  assign w_accept = (r_state == IDLE) && en_i && !kill_i && !reset;

  assign w_hit = CACHE_EN && r_cache_valid && (r_cache_op == w_op) &&
                 (r_cache_a == first_operand_i) && (r_cache_b == second_operand_i);

  // Upper 17 bits all equal: the operand is a sign-extended 16-bit value.
  assign w_narrow = NARROW_EN && (w_op == MUL) &&
                    ((&first_operand_i[31:15])  || !(|first_operand_i[31:15])) &&
                    ((&second_operand_i[31:15]) || !(|second_operand_i[31:15]));

  always_comb begin
    w_next_state         = r_state;
    w_latch              = 1'b0;
    w_cache_wr           = 1'b0;
    hold_o               = 1'b0;
    result_valid_o       = 1'b0;
    result_o             = 32'd0;
    mul_first_operand_o  = 32'd0;
    mul_second_operand_o = 32'd0;
    mul_signed_mode_o    = 2'b00;
    mul_enable_o         = 1'b0;
    mul_low_o            = 1'b0;
    mul_single_cycle_o   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_hit) begin
            result_valid_o = 1'b1;
            result_o       = r_cache_data;
          end else begin
            mul_first_operand_o  = w_cur_a;
            mul_second_operand_o = w_cur_b;
            mul_signed_mode_o    = signed_mode(w_cur_op);
            mul_low_o            = (w_cur_op == MUL);
            if (w_narrow) begin
              mul_single_cycle_o = 1'b1;
              result_valid_o     = 1'b1;
              result_o           = mul_result_i;
              w_cache_wr         = 1'b1;
            end else begin
              mul_enable_o = 1'b1;
              hold_o       = 1'b1;
              w_latch      = 1'b1;
              w_next_state = BUSY;
            end
          end
        end
      end

      BUSY, DRAIN: begin
        // The multiplier must be stepped to completion even after a flush so
        // that it returns to its first phase before the next launch.
        mul_enable_o         = 1'b1;
        mul_first_operand_o  = w_cur_a;
        mul_second_operand_o = w_cur_b;
        mul_signed_mode_o    = signed_mode(w_cur_op);
        mul_low_o            = (w_cur_op == MUL);
        if (r_state == DRAIN) begin
          if (!mul_hold_i) w_next_state = IDLE;
        end else if (kill_i) begin
          w_next_state = mul_hold_i ? DRAIN : IDLE;
        end else begin
          hold_o = mul_hold_i;
          if (!mul_hold_i) begin
            result_valid_o = 1'b1;
            result_o       = mul_result_i;
            w_cache_wr     = 1'b1;
            w_next_state   = IDLE;
          end
        end
      end

      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_op          <= MUL;
      r_a           <= 32'd0;
      r_b           <= 32'd0;
      r_cache_valid <= 1'b0;
      r_cache_op    <= MUL;
      r_cache_a     <= 32'd0;
      r_cache_b     <= 32'd0;
      r_cache_data  <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (w_latch) begin
        r_op <= w_op;
        r_a  <= first_operand_i;
        r_b  <= second_operand_i;
      end
      if (CACHE_EN && w_cache_wr) begin
        r_cache_valid <= 1'b1;
        r_cache_op    <= w_cur_op;
        r_cache_a     <= w_cur_a;
        r_cache_b     <= w_cur_b;
        r_cache_data  <= mul_result_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mul_issue                                                     |
// | Purpose : Self-checking bench for mul_issue with a behavioural iterative   |
// |           multiplier, a reference model and a result scoreboard.           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_mul_issue;
  import mul_issue_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_i;
  logic        kill_i;
  logic [1:0]  op_i;
  logic [31:0] first_operand_i;
  logic [31:0] second_operand_i;
  logic        hold_o;
  logic        result_valid_o;
  logic [31:0] result_o;
  logic [31:0] mul_first_operand_o;
  logic [31:0] mul_second_operand_o;
  logic [1:0]  mul_signed_mode_o;
  logic        mul_enable_o;
  logic        mul_low_o;
  logic        mul_single_cycle_o;
  logic        mul_hold_i;
  logic [31:0] mul_result_i;

  mul_issue #(.NARROW_EN(1'b1), .CACHE_EN(1'b1)) dut (
    .clk                  (clk),
    .reset                (reset),
    .en_i                 (en_i),
    .kill_i               (kill_i),
    .op_i                 (op_i),
    .first_operand_i      (first_operand_i),
    .second_operand_i     (second_operand_i),
    .hold_o               (hold_o),
    .result_valid_o       (result_valid_o),
    .result_o             (result_o),
    .mul_first_operand_o  (mul_first_operand_o),
    .mul_second_operand_o (mul_second_operand_o),
    .mul_signed_mode_o    (mul_signed_mode_o),
    .mul_enable_o         (mul_enable_o),
    .mul_low_o            (mul_low_o),
    .mul_single_cycle_o   (mul_single_cycle_o),
    .mul_hold_i           (mul_hold_i),
    .mul_result_i         (mul_result_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural iterative multiplier ----------------
  // Low-word ops finish on the 3rd enabled cycle, high-word ops on the 4th.
  int          mcnt;
  int          mlat;
  longint      mx, my;
  logic [63:0] mprod;

  always @(posedge clk or posedge reset) begin
    if (reset) mcnt <= 0;
    else if (mul_enable_o && !mul_single_cycle_o && mul_hold_i) mcnt <= mcnt + 1;
    else mcnt <= 0;
  end

  assign mlat       = mul_low_o ? 3 : 4;
  assign mul_hold_i = mul_enable_o && !mul_single_cycle_o && (mcnt < mlat - 1);
  assign mx = mul_signed_mode_o[0] ? longint'($signed(mul_first_operand_o))
                                   : longint'({32'd0, mul_first_operand_o});
  assign my = mul_signed_mode_o[1] ? longint'($signed(mul_second_operand_o))
                                   : longint'({32'd0, mul_second_operand_o});
  assign mprod        = mx * my;
  assign mul_result_i = mul_low_o ? mprod[31:0] : mprod[63:32];

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] res;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  logic        ref_valid;
  logic [1:0]  ref_op;
  logic [31:0] ref_a, ref_b, ref_r;

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      x, y;
    logic [63:0] p;
    x = (op == 2'b11) ? longint'({32'd0, a}) : longint'($signed(a));
    y = (op == 2'b00 || op == 2'b01) ? longint'($signed(b)) : longint'({32'd0, b});
    p = x * y;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic bit fits16(input logic [31:0] v);
    return ($signed(v) >= -32768) && ($signed(v) <= 32767);
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [7:0] holds, output logic en0, output logic sc0);
    exp_t e;
    int   n;
    e.res = ref_mul(op, a, b);
    e.cyc = cyc;
    if (ref_valid && ref_op == op && ref_a == a && ref_b == b) e.lat = 1;
    else if (op == 2'b00 && fits16(a) && fits16(b))            e.lat = 1;
    else if (op == 2'b00)                                      e.lat = 3;
    else                                                       e.lat = 4;
    ref_valid = 1'b1; ref_op = op; ref_a = a; ref_b = b; ref_r = e.res;
    sb.push_back(e);
    en_i = 1'b1; op_i = op; first_operand_i = a; second_operand_i = b;
    holds = '0; en0 = 1'b0; sc0 = 1'b0; n = 0;
    do begin
      @(negedge clk);
      if (n == 0) begin en0 = mul_enable_o; sc0 = mul_single_cycle_o; end
      if (n < 8) holds[n] = hold_o;
      n++;
    end while (!result_valid_o && n < 20);
    if (!result_valid_o) fail_now("result_timeout");
    @(posedge clk); #1;
    en_i = 1'b0;
  endtask

  // Monitor: every valid pops one expectation; otherwise result must be 0.
  always @(negedge clk) begin
    exp_t e;
    if (result_valid_o) begin
      if (sb.size() == 0) fail_now("unexpected_valid");
      else begin
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("latency", cyc - e.cyc + 1, e.lat);
      end
    end else begin
      chk("result_zero", result_o, 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  h;
    logic        e0, s0;
    logic [1:0]  op;
    logic [31:0] a, b;
    int          n;

    reset = 1'b1; en_i = 1'b0; kill_i = 1'b0; op_i = 2'b00;
    first_operand_i = 32'd0; second_operand_i = 32'd0;
    ref_valid = 1'b0; ref_op = 2'b00; ref_a = 0; ref_b = 0; ref_r = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold", {31'd0, hold_o}, 32'd0);
    chk("rst_valid", {31'd0, result_valid_o}, 32'd0);
    chk("rst_mul_ctrl", {28'd0, mul_enable_o, mul_low_o, mul_single_cycle_o, |mul_signed_mode_o}, 32'd0);
    chk("rst_mul_ops", mul_first_operand_o | mul_second_operand_o, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, h, e0, s0);
    chk("mulhu_holds", {28'd0, h[3:0]}, 32'h7);
    chk("mulhu_enable", {31'd0, e0}, 32'd1);
    issue(2'b00, 32'h00012345, 32'h00000010, h, e0, s0);
    chk("mul_wide_holds", {29'd0, h[2:0]}, 32'h3);
    issue(2'b00, 32'hFFFF8000, 32'h00007FFF, h, e0, s0);
    chk("narrow_enable", {31'd0, e0}, 32'd0);
    chk("narrow_single", {31'd0, s0}, 32'd1);
    chk("narrow_hold", {31'd0, h[0]}, 32'd0);
    issue(2'b00, 32'h00008000, 32'h00000001, h, e0, s0);
    chk("narrow_edge_holds", {29'd0, h[2:0]}, 32'h3);
    issue(2'b01, 32'h80000000, 32'h80000000, h, e0, s0);
    issue(2'b01, 32'h80000000, 32'h80000000, h, e0, s0);
    chk("hit_enable", {31'd0, e0}, 32'd0);
    chk("hit_hold", {31'd0, h[0]}, 32'd0);
    issue(2'b11, 32'h80000000, 32'h80000000, h, e0, s0);
    chk("op_miss_holds", {28'd0, h[3:0]}, 32'h7);

    // Flush in the second cycle of a MULHSU
    en_i = 1'b1; op_i = 2'b10; first_operand_i = 32'hFFFFFFFF; second_operand_i = 32'h2;
    @(negedge clk);
    chk("kill_accept_hold", {31'd0, hold_o}, 32'd1);
    @(posedge clk); #1;
    en_i = 1'b0; kill_i = 1'b1;
    @(negedge clk);
    chk("kill_hold", {31'd0, hold_o}, 32'd0);
    chk("kill_valid", {31'd0, result_valid_o}, 32'd0);
    @(posedge clk); #1;
    kill_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      chk("drain_hold", {31'd0, hold_o}, 32'd0);
      chk("drain_enable", {31'd0, mul_enable_o}, 32'd1);
      n++;
    end while (mul_hold_i && n < 20);
    if (mul_hold_i) fail_now("drain_timeout");
    @(posedge clk); #1;
    issue(2'b10, 32'hFFFFFFFF, 32'h00000002, h, e0, s0);

    // Reset in the middle of a MULH
    en_i = 1'b1; op_i = 2'b01; first_operand_i = 32'd3; second_operand_i = 32'd5;
    @(posedge clk); #1;
    en_i = 1'b0;
    @(negedge clk);
    chk("busy_hold", {31'd0, hold_o}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_hold", {31'd0, hold_o}, 32'd0);
    chk("rst_mid_valid", {31'd0, result_valid_o}, 32'd0);
    chk("rst_mid_enable", {31'd0, mul_enable_o}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ref_valid = 1'b0;
    issue(2'b00, 32'd7, 32'd6, h, e0, s0);

    // Randomized traffic with narrow-range values and exact repeats
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          op = 2'($urandom_range(0, 3));
          a  = $urandom; b = $urandom;
        end
        2: begin
          op = 2'($urandom_range(0, 3));
          a  = 32'($signed($urandom_range(0, 80000)) - 40000);
          b  = 32'($signed($urandom_range(0, 80000)) - 40000);
        end
        default: begin
          op = ref_op; a = ref_a; b = ref_b;
        end
      endcase
      issue(op, a, b, h, e0, s0);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    if (sb.size() != 0) fail_now("scoreboard_not_empty");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
